// File: rtl/qr_pkg.sv
// qr_pkg: shared types and constants for the QR grid sampler.
//   sampler_state_t : FSM state encoding (IDLE, SETUP, SCAN, DRAIN, EMIT, DONE)
//   FINDER_OFFSET   : module index of the finder-pattern centre (3)
//   GRID/IMG_W/IMG_H defaults for a version-1 code in a 320x240 frame
//   COORD_W         : signed width of the grid-corner coordinates
package qr_pkg;

  localparam int GRID_DEF      = 21;
  localparam int IMG_W_DEF     = 320;
  localparam int IMG_H_DEF     = 240;
  localparam int FINDER_OFFSET = 3;

  // Wide enough that cx + (GRID-4)*m cannot overflow for any 9-bit cx and m.
  localparam int COORD_W       = 16;

  typedef logic [2:0] sampler_state_t;

  localparam sampler_state_t S_IDLE  = 3'd0;
  localparam sampler_state_t S_SETUP = 3'd1;
  localparam sampler_state_t S_SCAN  = 3'd2;
  localparam sampler_state_t S_DRAIN = 3'd3;
  localparam sampler_state_t S_EMIT  = 3'd4;
  localparam sampler_state_t S_DONE  = 3'd5;

endpackage

// File: rtl/qr_grid_addr_gen.sv
// qr_grid_addr_gen: frame-buffer address stepping for the grid sampler.
// Holds the current row base and walks across the row one sample per step.
// Optional feature macro: QR_GRID_SAMPLER_MAJORITY_EN -- three taps per
// module at x-1, x, x+1; tap_last marks the third tap.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   load, base      : start a frame at row base 'base'
//   step            : advance to the next sample in the row
//   next_row        : advance the row base by 'stride' and restart the row
//   stride, mod_size: row stride (m*IMG_W) and module size m
//   addr            : registered frame-buffer read address
//   tap_last        : current sample is the last tap of its module
module qr_grid_addr_gen
  import qr_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              next_row,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [8:0]        mod_size,
  output logic [ADDR_W-1:0] addr,
  output logic              tap_last
);

  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] row_base_next;
  logic [ADDR_W-1:0] step_m;

  assign row_base_next = row_base + stride;
  assign step_m        = ADDR_W'(mod_size);

`ifdef QR_GRID_SAMPLER_MAJORITY_EN
  logic [1:0] phase;

  assign tap_last = (phase == 2'd2);

  // Taps run x-1, x, x+1; after the third tap jump m-2 to the next left tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base <= '0;
      addr     <= '0;
      phase    <= 2'd0;
    end else if (load) begin
      row_base <= base;
      addr     <= base - ADDR_W'(1);
      phase    <= 2'd0;
    end else if (next_row) begin
      row_base <= row_base_next;
      addr     <= row_base_next - ADDR_W'(1);
      phase    <= 2'd0;
    end else if (step) begin
      if (tap_last) begin
        addr  <= addr + step_m - ADDR_W'(2);
        phase <= 2'd0;
      end else begin
        addr  <= addr + ADDR_W'(1);
        phase <= phase + 2'd1;
      end
    end
  end
`else
  assign tap_last = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base <= '0;
      addr     <= '0;
    end else if (load) begin
      row_base <= base;
      addr     <= base;
    end else if (next_row) begin
      row_base <= row_base_next;
      addr     <= row_base_next;
    end else if (step) begin
      addr <= addr + step_m;
    end
  end
`endif

endmodule

// File: rtl/qr_grid_sampler.sv
// qr_grid_sampler: samples a thresholded frame at every QR module centre and
// emits the bit grid one row at a time.
// Optional feature macro: QR_GRID_SAMPLER_MAJORITY_EN -- 2-of-3 majority over
// x-1, x, x+1 per module, 3*GRID scan cycles per row, 1-pixel wider bounds.
// Ports:
//   clk_in, rst_n_in     : clock, asynchronous active-low reset
//   start_in             : start pulse (from mod_size_valid), IDLE only
//   center_x_in/_y_in    : top-left finder centre, latched on start
//   mod_size_in          : module size in pixels, latched on start
//   pixel_addr_out       : BRAM read address y*IMG_W+x
//   pixel_data_in        : BRAM read data, READ_LATENCY cycles after address
//   row_out/row_index_out: sampled row (bit c = column c) and its number
//   row_valid_out        : one-cycle row strobe
//   busy_out             : frame in progress
//   done_out/error_out   : end-of-frame pulse, error if grid out of bounds
module qr_grid_sampler
  import qr_pkg::*;
#(
  parameter int GRID         = GRID_DEF,
  parameter int IMG_W        = IMG_W_DEF,
  parameter int IMG_H        = IMG_H_DEF,
  parameter int ADDR_W       = 17,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic [8:0]        center_x_in,
  input  logic [8:0]        center_y_in,
  input  logic [8:0]        mod_size_in,
  output logic [ADDR_W-1:0] pixel_addr_out,
  input  logic              pixel_data_in,
  output logic [GRID-1:0]   row_out,
  output logic [4:0]        row_index_out,
  output logic              row_valid_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              error_out
);

`ifdef QR_GRID_SAMPLER_MAJORITY_EN
  localparam int TAPS   = 3;
  localparam int MARGIN = 1;
`else
  localparam int TAPS   = 1;
  localparam int MARGIN = 0;
`endif

  localparam int SCAN_LEN = TAPS * GRID;
  localparam int SCAN_CW  = $clog2(SCAN_LEN + 1);
  localparam int DRAIN_CW = $clog2(READ_LATENCY + 1);

  localparam logic [SCAN_CW-1:0]  SCAN_LAST  = SCAN_CW'(SCAN_LEN - 1);
  localparam logic [DRAIN_CW-1:0] DRAIN_LAST = DRAIN_CW'(READ_LATENCY - 1);
  localparam logic [4:0]          ROW_LAST   = 5'(GRID - 1);

  localparam logic signed [COORD_W-1:0] OFF_S    = COORD_W'(FINDER_OFFSET);
  localparam logic signed [COORD_W-1:0] LAST_S   = COORD_W'(GRID - 1 - FINDER_OFFSET);
  localparam logic signed [COORD_W-1:0] MARGIN_S = COORD_W'(MARGIN);
  localparam logic signed [COORD_W-1:0] IMG_W_S  = COORD_W'(IMG_W);
  localparam logic signed [COORD_W-1:0] IMG_H_S  = COORD_W'(IMG_H);
  localparam logic [ADDR_W-1:0]         IMG_W_A  = ADDR_W'(IMG_W);

  sampler_state_t state;
  logic                setup_p1;
  logic [SCAN_CW-1:0]  scan_cnt;
  logic [DRAIN_CW-1:0] drain_cnt;
  logic [4:0]          row;
  logic                err;

  logic [8:0] cx, cy, m;
  logic signed [COORD_W-1:0] cx_s, cy_s, m_s;
  logic signed [COORD_W-1:0] x_first, x_last, y_first, y_last;
  logic [ADDR_W-1:0] row_stride;
  logic [ADDR_W-1:0] row_base0;
  logic              oob;

  logic [READ_LATENCY-1:0] tag_vld, tag_last;
  logic                    tap_last;
  logic                    shift_en;
  logic                    sample;
  logic [GRID-1:0]         shreg, shreg_next;

  logic addr_load, addr_step, addr_next_row;

  assign cx_s = $signed(COORD_W'(cx));
  assign cy_s = $signed(COORD_W'(cy));
  assign m_s  = $signed(COORD_W'(m));

  assign oob = (m == 9'd0) || (x_first < MARGIN_S) || y_first[COORD_W-1] ||
               (x_last + MARGIN_S >= IMG_W_S) || (y_last >= IMG_H_S);

  // Only meaningful when in bounds, where both corners are non-negative.
  assign row_base0 = ADDR_W'(y_first) * IMG_W_A + ADDR_W'(x_first);

  assign addr_load     = (state == S_SETUP) && setup_p1 && !oob;
  assign addr_step     = (state == S_SCAN) && (scan_cnt != SCAN_LAST);
  assign addr_next_row = (state == S_EMIT) && (row != ROW_LAST);

  qr_grid_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .load     (addr_load),
    .step     (addr_step),
    .next_row (addr_next_row),
    .base     (row_base0),
    .stride   (row_stride),
    .mod_size (m),
    .addr     (pixel_addr_out),
    .tap_last (tap_last)
  );

  assign shift_en = tag_vld[READ_LATENCY-1] & tag_last[READ_LATENCY-1];

`ifdef QR_GRID_SAMPLER_MAJORITY_EN
  logic [1:0] tap_buf;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign sample = maj3(tap_buf[1], tap_buf[0], pixel_data_in);

  always_ff @(posedge clk_in) begin
    if (tag_vld[READ_LATENCY-1] && !tag_last[READ_LATENCY-1])
      tap_buf <= {tap_buf[0], pixel_data_in};
  end
`else
  assign sample = pixel_data_in;
`endif

  // New samples enter at the top so column 0 ends at bit 0 after GRID shifts.
  assign shreg_next = {sample, shreg[GRID-1:1]};

  // Stage p0: latch frame parameters, corner coordinates and returned bits
  always_ff @(posedge clk_in) begin
    if (state == S_IDLE && start_in) begin
      cx <= center_x_in;
      cy <= center_y_in;
      m  <= mod_size_in;
    end
    if (state == S_SETUP && !setup_p1) begin
      x_first    <= cx_s - m_s * OFF_S;
      x_last     <= cx_s + m_s * LAST_S;
      y_first    <= cy_s - m_s * OFF_S;
      y_last     <= cy_s + m_s * LAST_S;
      row_stride <= ADDR_W'(m) * IMG_W_A;
    end
    if (shift_en)
      shreg <= shreg_next;
  end

  // Stage p1: control FSM, read tags and registered outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= S_IDLE;
      setup_p1      <= 1'b0;
      scan_cnt      <= '0;
      drain_cnt     <= '0;
      row           <= 5'd0;
      err           <= 1'b0;
      tag_vld       <= '0;
      tag_last      <= '0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      error_out     <= 1'b0;
      row_valid_out <= 1'b0;
      row_out       <= '0;
      row_index_out <= 5'd0;
    end else begin
      done_out      <= 1'b0;
      error_out     <= 1'b0;
      row_valid_out <= 1'b0;

      tag_vld[0]  <= (state == S_SCAN);
      tag_last[0] <= tap_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_last[i] <= tag_last[i-1];
      end

      case (state)
        S_IDLE: begin
          if (start_in) begin
            state    <= S_SETUP;
            setup_p1 <= 1'b0;
            busy_out <= 1'b1;
            err      <= 1'b0;
            row      <= 5'd0;
          end
        end
        S_SETUP: begin
          if (!setup_p1) begin
            setup_p1 <= 1'b1;
          end else begin
            setup_p1 <= 1'b0;
            if (oob) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              scan_cnt <= '0;
              state    <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (scan_cnt == SCAN_LAST) begin
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end else begin
            scan_cnt <= scan_cnt + SCAN_CW'(1);
          end
        end
        S_DRAIN: begin
          // The last column's bit arrives in the final drain cycle.
          if (drain_cnt == DRAIN_LAST) begin
            row_out       <= shreg_next;
            row_index_out <= row;
            row_valid_out <= 1'b1;
            state         <= S_EMIT;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_CW'(1);
          end
        end
        S_EMIT: begin
          if (row == ROW_LAST) begin
            state <= S_DONE;
          end else begin
            row      <= row + 5'd1;
            scan_cnt <= '0;
            state    <= S_SCAN;
          end
        end
        S_DONE: begin
          done_out  <= 1'b1;
          error_out <= err;
          busy_out  <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
